// File: rtl/descramble_arbiter.sv
// rtl/descramble_arbiter.sv - round-robin arbiter sharing one iterative LFSR address descrambler
module descramble_arbiter #(
    parameter int NREQ   = 4,
    parameter int AW     = 12,
    parameter int ROUNDS = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*AW-1:0]        addr_in,
    input  logic [NREQ*16-1:0]        key_in,
    output logic [NREQ-1:0]           grant,
    output logic                      busy,
    output logic                      out_valid,
    output logic [AW-1:0]             out_addr,
    output logic [$clog2(NREQ)-1:0]   out_id,
    input  logic                      out_ready
);

    localparam int IDW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [AW-1:0]   ONE_AW   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [NREQ-1:0] ONE_NREQ = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [4:0]      LAST_RND = 5'(ROUNDS - 1);

    logic [1:0]     state;
    logic [4:0]     cnt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] id;
    logic [AW-1:0]  r;
    logic [15:0]    key;

    logic [IDW-1:0] sel;
    logic           sel_found;
    logic [AW-1:0]  sel_addr;
    logic [15:0]    sel_key;
    int             idx;

    logic [AW-1:0]  t;
    logic           f;
    logic [AW-1:0]  r_next;

    assign busy = (state == S_RUN) || (state == S_DONE);

    // First requesting index at or above the RR pointer, wrapping, plus its address/key
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!sel_found && req[IDW'(idx)]) begin
                sel_found = 1'b1;
                sel       = IDW'(idx);
            end
        end
        sel_addr = '0;
        sel_key  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == sel) begin
                sel_addr = addr_in[i*AW +: AW];
                sel_key  = key_in[i*16 +: 16];
            end
        end
    end

    // One LFSR round: rotate right, then the MSB becomes the XOR of up to four taps;
    // a tap index beyond the register shifts the mask bit out and so contributes 0
    always_comb begin
        t      = {r[0], r[AW-1:1]};
        f      = (|(t & (ONE_AW << key[3:0])))   ^ (|(t & (ONE_AW << key[7:4]))) ^
                 (|(t & (ONE_AW << key[11:8])))  ^ (|(t & (ONE_AW << key[15:12])));
        r_next = {f, t[AW-2:0]};
    end

    // Arbitration, round sequencing and output handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rr_ptr    <= '0;
            id        <= '0;
            r         <= '0;
            key       <= '0;
            grant     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_id    <= '0;
        end else begin
            grant <= '0;
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        grant <= ONE_NREQ << sel;
                        r     <= sel_addr;
                        key   <= sel_key;
                        id    <= sel;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r   <= r_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST_RND) begin
                        out_addr  <= r_next;
                        out_valid <= 1'b1;
                        out_id    <= id;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rr_ptr    <= (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_descramble_arbiter.sv
// tb/tb_descramble_arbiter.sv - scoreboard bench for descramble_arbiter
module tb_descramble_arbiter;

    localparam int NREQ   = 4;
    localparam int AW     = 12;
    localparam int ROUNDS = 12;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   addr_in;
    logic [NREQ*16-1:0]   key_in;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 out_valid;
    logic [AW-1:0]        out_addr;
    logic [1:0]           out_id;
    logic                 out_ready;

    descramble_arbiter #(.NREQ(NREQ), .AW(AW), .ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .addr_in   (addr_in),
        .key_in    (key_in),
        .grant     (grant),
        .busy      (busy),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {int id; int addr;} exp_t;
    exp_t sbq[$];
    int   grant_log[$];
    int   grant_times[$];

    int              cyc = 0;
    logic [NREQ-1:0] prev_req = '0;
    int              model_ptr = 0;
    bit              model_busy = 0;
    int              grant_cyc = 0;
    bit              prev_valid = 0;
    logic [AW-1:0]   hold_addr;
    logic [1:0]      hold_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: rotate right, MSB replaced by XOR of taps that fall inside the register
    function automatic int ref_descramble(input int a, input int k);
        int r;
        int tt;
        int f;
        int tap;
        r = a;
        for (int n = 0; n < ROUNDS; n++) begin
            tt = (r >> 1) | ((r & 1) << (AW - 1));
            f  = 0;
            for (int j = 0; j < 4; j++) begin
                tap = (k >> (4 * j)) & 15;
                if (tap < AW) f = f ^ ((tt >> tap) & 1);
            end
            r = (tt & ((1 << (AW - 1)) - 1)) | (f << (AW - 1));
        end
        return r;
    endfunction

    // Monitor: predicts grants from the sampled request vector, queues expected
    // results, and checks every presented result, its latency and its stability
    initial begin
        int   w;
        int   ix;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                sbq.delete();
                model_ptr  = 0;
                model_busy = 0;
                prev_valid = 0;
            end else begin
                if (grant != '0) begin
                    w = -1;
                    for (int i = 0; i < NREQ; i++) begin
                        ix = (model_ptr + i) % NREQ;
                        if (w < 0 && prev_req[ix]) w = ix;
                    end
                    check("grant_while_busy", 32'(model_busy), 0);
                    if (w < 0) begin
                        check("grant_without_req", 32'(grant), 0);
                    end else begin
                        check("grant_winner", 32'(grant), 32'(1 << w));
                        e.id   = w;
                        e.addr = ref_descramble(int'(addr_in[w*AW +: AW]), int'(key_in[w*16 +: 16]));
                        sbq.push_back(e);
                        model_busy = 1;
                        grant_cyc  = cyc;
                        grant_log.push_back(w);
                        grant_times.push_back(cyc);
                    end
                end
                check("busy", 32'(busy), 32'(model_busy));
                if (out_valid) begin
                    if (!prev_valid) begin
                        check("latency", 32'(cyc - grant_cyc), ROUNDS);
                        check("output_expected", 32'(sbq.size() != 0), 1);
                        hold_addr = out_addr;
                        hold_id   = out_id;
                    end else begin
                        check("hold_addr", 32'(out_addr), 32'(hold_addr));
                        check("hold_id", 32'(out_id), 32'(hold_id));
                    end
                    if (out_ready && sbq.size() != 0) begin
                        e = sbq.pop_front();
                        check("result_addr", 32'(out_addr), 32'(e.addr));
                        check("result_id", 32'(out_id), 32'(e.id));
                        model_ptr  = (e.id + 1) % NREQ;
                        model_busy = 0;
                    end
                end
                prev_valid = out_valid && !out_ready;
            end
            prev_req = req;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [15:0] k);
        addr_in[i*AW +: AW] = a;
        key_in[i*16 +: 16]  = k;
        req[i]              = 1'b1;
    endtask

    task automatic wait_grant(input int i);
        bit ok;
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            tick();
            if (grant[i]) ok = 1;
        end
        check("wait_grant_seen", 32'(ok), 1);
    endtask

    task automatic wait_result(output logic [AW-1:0] a, output logic [1:0] id);
        bit ok;
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (out_valid) ok = 1;
            else tick();
        end
        check("wait_result_seen", 32'(ok), 1);
        a  = out_addr;
        id = out_id;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 300 && !ok; n++) begin
            if (!busy) ok = 1;
            else tick();
        end
        check("wait_idle_reached", 32'(ok), 1);
    endtask

    initial begin
        logic [AW-1:0] ga;
        logic [1:0]    gi;
        logic [AW-1:0] ra;
        int            pend;
        bit            gseen [NREQ];

        reset = 1'b1; req = '0; addr_in = '0; key_in = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_addr", 32'(out_addr), 0);
        check("rst_id", 32'(out_id), 0);
        reset = 1'b0;

        // All four taps on bit 0 cancel: plain shift, result drains to zero
        set_req(0, 12'hABC, 16'h0000);
        wait_grant(0);
        tick();
        check("t1_grant_one_cycle", 32'(grant), 0);
        req[0] = 1'b0;
        wait_result(ga, gi);
        check("t1_addr", 32'(ga), 32'h000);
        check("t1_id", 32'(gi), 0);
        wait_idle();

        // Single tap on the rotated MSB: pure rotation, identity after 12 rounds
        set_req(2, 12'hABC, 16'hFFFB);
        wait_grant(2);
        tick();
        req[2] = 1'b0;
        wait_result(ga, gi);
        check("t2_addr", 32'(ga), 32'hABC);
        check("t2_id", 32'(gi), 2);
        wait_idle();

        // Out-of-range taps contribute nothing
        ra = 12'($urandom_range(0, 4095));
        set_req(1, ra, 16'hCDEB);
        wait_grant(1);
        tick();
        req[1] = 1'b0;
        wait_result(ga, gi);
        check("t6_addr", 32'(ga), 32'(ra));
        check("t6_id", 32'(gi), 1);
        wait_idle();

        // Round-robin with all requesters held high
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        grant_log.delete();
        grant_times.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, 12'($urandom), 16'($urandom));
        pend = -1;
        for (int n = 0; n < 200 && grant_log.size() < 5; n++) begin
            tick();
            if (pend >= 0) begin
                set_req(pend, 12'($urandom), 16'($urandom));
                pend = -1;
            end
            for (int i = 0; i < NREQ; i++) if (grant[i]) pend = i;
        end
        req = '0;
        check("rr_count", 32'(grant_log.size()), 5);
        if (grant_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) check("rr_order", 32'(grant_log[k]), 32'(k % NREQ));
            for (int k = 0; k < 4; k++) check("rr_spacing", 32'(grant_times[k+1] - grant_times[k]), ROUNDS + 2);
        end
        wait_idle();

        // Backpressure: result must hold, no grant while waiting
        out_ready = 1'b0;
        set_req(3, 12'($urandom), 16'($urandom));
        wait_grant(3);
        tick();
        req[3] = 1'b0;
        wait_result(ga, gi);
        set_req(0, 12'($urandom), 16'($urandom));
        for (int n = 0; n < 20; n++) begin
            tick();
            check("bp_valid", 32'(out_valid), 1);
            check("bp_no_grant", 32'(grant), 0);
            check("bp_busy", 32'(busy), 1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_released", 32'(out_valid), 0);
        wait_grant(0);
        tick();
        req[0] = 1'b0;
        wait_idle();

        // Reset in the middle of RUN aborts without output
        set_req(1, 12'($urandom), 16'($urandom));
        wait_grant(1);
        for (int n = 0; n < 4; n++) tick();
        reset  = 1'b1;
        req[1] = 1'b0;
        set_req(3, 12'($urandom), 16'($urandom));
        tick();
        check("mrst_grant", 32'(grant), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_valid", 32'(out_valid), 0);
        check("mrst_addr", 32'(out_addr), 0);
        check("mrst_id", 32'(out_id), 0);
        reset = 1'b0;
        wait_grant(3);
        tick();
        req[3] = 1'b0;
        wait_result(ga, gi);
        check("mrst_result_id", 32'(gi), 3);
        wait_idle();

        // Randomized traffic with random backpressure
        for (int i = 0; i < NREQ; i++) gseen[i] = 0;
        for (int n = 0; n < 1500; n++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (gseen[i]) begin
                    gseen[i] = 0;
                    if ($urandom_range(0, 1) == 1) set_req(i, 12'($urandom), 16'($urandom));
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 7) == 0) begin
                    set_req(i, 12'($urandom), 16'($urandom));
                end
                if (grant[i]) gseen[i] = 1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
        if (grant != '0) tick();
        req = '0;
        tick();
        wait_idle();
        tick();
        check("drain_empty", 32'(sbq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
